uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with a built-in receive FIFO and error/interrupt reporting.
- Successor to the fixed 8N1, single-byte-buffer receiver inside the peripheral block.
- Configurable in bit period, data width, parity mode and FIFO depth.
- Sits between the UART_RX pin and the peripheral register file; the CPU drains bytes via a valid/ready pop port and uses irq for interrupt-driven reception.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per bit (50 MHz / 9600 baud); must be >= 8.
- DATA_BITS, 8: data bits per frame, legal range 5..8.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 16: entries; power of two, >= 2.
- IRQ_THRESH, 1: irq asserts when count >= IRQ_THRESH; legal range 1..FIFO_DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- UART_RX  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  head-of-FIFO data.
- rx_perr  out  1  parity error flag for the head entry.
- rx_ferr  out  1  framing error flag for the head entry.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop request; a pop occurs when rx_valid && rx_ready.
- count  out  log2(FIFO_DEPTH)+1  current occupancy.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- ovr_clr  in  1  clears overrun.
- irq  out  1  (count >= IRQ_THRESH) | overrun.

Behaviour:
- Reset: synchronous, active-high. All outputs are 0, FIFO is empty, FSM is IDLE, the synchroniser flops are preset to 1, and the bit counter is 0. A reset mid-frame aborts the frame and no push occurs.
- Input synchroniser: two flops, so rxs lags UART_RX by 2 cycles. All decisions below use rxs.
- IDLE:
  - Stay here while rxs = 1.
  - On rxs = 0, load the counter with CLKS_PER_BIT/2 - 1 and go to START.
- START: at counter expiry (mid-bit), sample rxs.
  - If 1: glitch; return to IDLE with no push and no flags.
  - If 0: reload the counter with CLKS_PER_BIT - 1 and go to DATA with bit index 0.
- DATA:
  - At each expiry, shift rxs into the shift register, LSB first, and reload the counter.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, otherwise go to STOP.
- PARITY: sample once at expiry.
  - perr = (XOR of data bits ^ sample) != 0 for even parity, == 0 for odd parity.
  - perr = 0 when PARITY_MODE = 0.
- STOP: sample at expiry.
  - ferr = ~sample.
  - Push {ferr, perr, data} in this same cycle; the byte is pushed even if it has errors.
  - If ferr = 0, go to IDLE.
  - If ferr = 1, go to BREAK.
- BREAK: wait for rxs = 1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Latency: rx_valid rises 1 cycle after the push cycle, i.e. the cycle after the stop-bit mid-sample, when the FIFO was empty.
- FIFO:
  - Show-ahead: rx_data, rx_perr and rx_ferr always reflect the head entry and are undefined (held) while empty.
  - Read/write pointers carry an extra wrap bit; count = wptr - rptr.
  - Pop on empty is ignored.
  - Push while full with no pop in the same cycle: the entry is dropped and overrun is set.
  - Push and pop in the same cycle while full: both are accepted; count stays at FIFO_DEPTH and overrun is not set.
  - Push and pop in the same cycle while empty: the push is accepted and the pop is ignored; count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH, and the data stays in order across the wrap.
- overrun:
  - Cleared by ovr_clr.
  - If ovr_clr and a new drop occur in the same cycle, set wins.
- irq is combinational from count and overrun (registered sources), with no extra latency.

Decomposition:
- Shared package uart_pkg holds:
  - the parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the FSM state encoding rx_state_t (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the clog2 helper function.
- One sub-module: sync_fifo, a parametrised width/depth show-ahead FIFO with count and full/empty flags, reused later by the TX path. The FSM, synchroniser and overrun logic stay in the top module.

Test Plan:
- Run all scenarios with CLKS_PER_BIT = 16. Frames from scenario 1 onward are driven on UART_RX.
- Frame 0xDC: start, bits 0,0,1,1,1,0,1,1, stop 1 -> rx_valid rises 1 cycle after the stop mid-sample; rx_data = 0xDC, perr = ferr = 0, count = 1, irq = 1. Then pulse rx_ready -> count = 0, irq = 0.
- Back-to-back 0xDC then 0xF0 (bits 0,0,0,0,1,1,1,1) with no pop in between -> count = 2; pops return 0xDC then 0xF0 in order.
- Glitch: hold UART_RX low for 4 cycles, then high -> no push, FSM back in IDLE, count = 0.
- PARITY_MODE = 1, byte 0x01 sent with parity bit 0 -> entry pushed with rx_perr = 1. Same byte with parity bit 1 -> rx_perr = 0.
- Stop bit 0 on byte 0x55, line held low for 3 bit times -> one entry with rx_ferr = 1 and no further frames until the line returns high.
- FIFO_DEPTH = 4: send 5 bytes (0x10..0x14) with no pops -> count = 4 and overrun = 1; pops return 0x10..0x13. Pulse ovr_clr -> overrun = 0. Repeat the full-FIFO case with a pop in the push cycle -> no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver
// state encoding and a constant-safe ceil(log2) helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; the head entry is
// always presented on o_data. Also intended for reuse by the TX path.
module sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [clog2(DEPTH):0]  o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity/bit period) feeding a show-ahead
// receive FIFO, with sticky overrun and a level interrupt.
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge on the synchronised input
//   START  | timing to mid start bit; a high sample there is treated as a glitch
//   DATA   | sampling DATA_BITS data bits LSB first at mid-bit
//   PARITY | sampling the parity bit
//   STOP   | sampling the stop bit; the frame is pushed in the same cycle
//   BREAK  | stop bit was low; hold off until the line returns high
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 16,
  parameter int IRQ_THRESH   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        UART_RX,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_perr,
  output logic                        rx_ferr,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [clog2(FIFO_DEPTH):0]  count,
  output logic                        overrun,
  input  logic                        ovr_clr,
  output logic                        irq
);

  localparam int                TW       = clog2(CLKS_PER_BIT);
  localparam int                CW       = clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]     T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]     T_FULL   = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [CW-1:0]     THR      = CW'(IRQ_THRESH);

  rx_state_t              r_state;
  logic [1:0]             r_sync;
  logic [TW-1:0]          r_tmr;
  logic [2:0]             r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr;
  logic                   r_overrun;

  logic                   w_rxs;
  logic                   w_tmr_done;
  logic                   w_par;
  logic                   w_push;
  logic [DATA_BITS+1:0]   w_push_data;
  logic [DATA_BITS+1:0]   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;

  assign w_rxs       = r_sync[1];
  assign w_tmr_done  = (r_tmr == '0);
  assign w_par       = (^r_shift) ^ w_rxs;
  assign w_push      = (r_state == STOP) && w_tmr_done;
  assign w_push_data = {~w_rxs, r_perr, r_shift};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_state   <= IDLE;
      r_tmr     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], UART_RX};
      if (!w_tmr_done) begin
        r_tmr <= r_tmr - TW'(1);
      end
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_tmr   <= T_HALF;
            r_state <= START;
          end
        end
        START: begin
          if (w_tmr_done) begin
            if (w_rxs) begin
              r_state <= IDLE;
            end else begin
              r_tmr     <= T_FULL;
              r_bit_idx <= '0;
              r_perr    <= 1'b0;
              r_state   <= DATA;
            end
          end
        end
        DATA: begin
          if (w_tmr_done) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_tmr   <= T_FULL;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (w_tmr_done) begin
            r_perr  <= (PARITY_MODE == PAR_ODD) ? ~w_par : w_par;
            r_tmr   <= T_FULL;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_tmr_done) begin
            r_state <= w_rxs ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (w_rxs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (rx_ready),
    .o_data  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A drop only happens when the head is not leaving in the same cycle.
  assign w_drop = w_push && w_full && !(rx_ready && !w_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign rx_data  = w_head[DATA_BITS-1:0];
  assign rx_perr  = w_head[DATA_BITS];
  assign rx_ferr  = w_head[DATA_BITS+1];
  assign rx_valid = !w_empty;
  assign overrun  = r_overrun;
  assign irq      = (count >= THR) | r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: three receiver instances (8N1 depth 16, even parity,
// depth 4) driven with hand-built serial frames at 16 clocks per bit.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rxl;
  logic [2:0] rdy;
  logic [2:0] clr;

  logic [7:0] d0, d1, d2;
  logic       pe0, pe1, pe2, fe0, fe1, fe2, v0, v1, v2;
  logic       ov0, ov1, ov2, irq0, irq1, irq2;
  logic [4:0] c0, c1;
  logic [2:0] c2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(16)) u0 (
    .clk(clk), .reset(reset), .UART_RX(rxl[0]), .rx_data(d0), .rx_perr(pe0),
    .rx_ferr(fe0), .rx_valid(v0), .rx_ready(rdy[0]), .count(c0),
    .overrun(ov0), .ovr_clr(clr[0]), .irq(irq0));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .PARITY_MODE(1)) u1 (
    .clk(clk), .reset(reset), .UART_RX(rxl[1]), .rx_data(d1), .rx_perr(pe1),
    .rx_ferr(fe1), .rx_valid(v1), .rx_ready(rdy[1]), .count(c1),
    .overrun(ov1), .ovr_clr(clr[1]), .irq(irq1));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .UART_RX(rxl[2]), .rx_data(d2), .rx_perr(pe2),
    .rx_ferr(fe2), .rx_valid(v2), .rx_ready(rdy[2]), .count(c2),
    .overrun(ov2), .ovr_clr(clr[2]), .irq(irq2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bit 0 = start, 1..8 = data LSB first, then stop (or parity, stop)
  function automatic logic [10:0] fr(input logic [7:0] b, input logic stop);
    return {1'b1, stop, b, 1'b0};
  endfunction

  function automatic logic [10:0] frp(input logic [7:0] b, input logic p);
    return {1'b1, p, b, 1'b0};
  endfunction

  // The last bit is held 16 cycles and left on the line; the push cycle is
  // the 11th cycle of the last bit (2 sync flops + 8-cycle half-bit offset).
  task automatic send(input int d, input logic [10:0] f, input int n,
                      input bit pop_at_push, input bit chk_lat);
    for (int i = 0; i < n - 1; i++) begin
      rxl[d] = f[i];
      tick(16);
    end
    rxl[d] = f[n-1];
    tick(10);
    if (chk_lat) chk("valid_before_push", 32'(v0), 0);
    if (pop_at_push) rdy[d] = 1'b1;
    tick(1);
    rdy[d] = 1'b0;
    if (chk_lat) chk("valid_after_push", 32'(v0), 1);
    tick(5);
  endtask

  task automatic pop(input int d);
    rdy[d] = 1'b1;
    tick(1);
    rdy[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rxl   = 3'b111;
    rdy   = 3'b000;
    clr   = 3'b000;
    reset = 1'b1;
    tick(3);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_count", 32'(c0), 0);
    chk("rst_irq", 32'(irq0), 0);
    chk("rst_overrun", 32'(ov0), 0);
    chk("rst_data", 32'(d0), 0);
    chk("rst_flags", 32'({pe0, fe0}), 0);
    reset = 1'b0;
    tick(2);

    // single frame with exact latency
    send(0, fr(8'hDC, 1'b1), 10, 1'b0, 1'b1);
    chk("dc_data", 32'(d0), 32'hDC);
    chk("dc_flags", 32'({pe0, fe0}), 0);
    chk("dc_count", 32'(c0), 1);
    chk("dc_irq", 32'(irq0), 1);
    pop(0);
    chk("dc_pop_count", 32'(c0), 0);
    chk("dc_pop_irq", 32'(irq0), 0);

    // back-to-back frames, ordered pops
    send(0, fr(8'hDC, 1'b1), 10, 1'b0, 1'b0);
    send(0, fr(8'hF0, 1'b1), 10, 1'b0, 1'b0);
    chk("b2b_count", 32'(c0), 2);
    chk("b2b_first", 32'(d0), 32'hDC);
    pop(0);
    chk("b2b_second", 32'(d0), 32'hF0);
    pop(0);
    chk("b2b_empty", 32'(c0), 0);

    // short low glitch, then a real frame still decodes
    rxl[0] = 1'b0;
    tick(4);
    rxl[0] = 1'b1;
    tick(40);
    chk("glitch_count", 32'(c0), 0);
    chk("glitch_valid", 32'(v0), 0);
    send(0, fr(8'hA5, 1'b1), 10, 1'b0, 1'b0);
    chk("post_glitch_data", 32'(d0), 32'hA5);
    chk("post_glitch_count", 32'(c0), 1);
    pop(0);

    // even parity
    send(1, frp(8'h01, 1'b0), 11, 1'b0, 1'b0);
    chk("par01_p0_perr", 32'(pe1), 1);
    chk("par01_p0_data", 32'(d1), 32'h01);
    pop(1);
    send(1, frp(8'h01, 1'b1), 11, 1'b0, 1'b0);
    chk("par01_p1_perr", 32'(pe1), 0);
    pop(1);
    send(1, frp(8'h03, 1'b0), 11, 1'b0, 1'b0);
    chk("par03_p0_perr", 32'(pe1), 0);
    chk("par03_ferr", 32'(fe1), 0);
    pop(1);
    chk("par_empty", 32'(c1), 0);

    // framing error with line held low for 3 bit times
    send(0, fr(8'h55, 1'b0), 10, 1'b0, 1'b0);
    tick(32);
    rxl[0] = 1'b1;
    tick(200);
    chk("ferr_count", 32'(c0), 1);
    chk("ferr_flag", 32'(fe0), 1);
    chk("ferr_data", 32'(d0), 32'h55);
    chk("ferr_perr", 32'(pe0), 0);
    pop(0);
    send(0, fr(8'h3C, 1'b1), 10, 1'b0, 1'b0);
    chk("recover_data", 32'(d0), 32'h3C);
    chk("recover_ferr", 32'(fe0), 0);
    pop(0);

    // depth-4 overrun
    for (int i = 0; i < 5; i++) send(2, fr(8'h10 + 8'(i), 1'b1), 10, 1'b0, 1'b0);
    chk("ovr_count", 32'(c2), 4);
    chk("ovr_flag", 32'(ov2), 1);
    chk("ovr_irq", 32'(irq2), 1);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_order", 32'(d2), 32'h10 + i);
      pop(2);
    end
    chk("ovr_drained", 32'(c2), 0);
    chk("ovr_sticky", 32'(ov2), 1);
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    chk("ovr_cleared", 32'(ov2), 0);
    chk("ovr_irq_clear", 32'(irq2), 0);

    // full FIFO, pop coincident with push: no drop
    for (int i = 0; i < 4; i++) send(2, fr(8'h20 + 8'(i), 1'b1), 10, 1'b0, 1'b0);
    chk("full_count", 32'(c2), 4);
    send(2, fr(8'h24, 1'b1), 10, 1'b1, 1'b0);
    chk("pp_count", 32'(c2), 4);
    chk("pp_overrun", 32'(ov2), 0);
    for (int i = 1; i < 5; i++) begin
      chk("pp_order", 32'(d2), 32'h20 + i);
      pop(2);
    end
    chk("pp_drained", 32'(c2), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
